// File: rtl/icu_sequencer.sv
// icu_sequencer: program sequencer for the 1-bit ICU.
// Holds the program counter, fetches words from a combinational program ROM,
// resolves flow control (JMP/RTN/SKZ/CALL) locally and forwards data opcodes
// plus their operand to the ICU one cycle after the fetch.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           level; begins execution from IDLE, returns HALT to IDLE when low
//   prog_addr       ROM address (= pc)
//   prog_data       {opcode[3:0], operand[ADDR_W-1:0]} for prog_addr, same cycle
//   I, io_addr      registered opcode / operand to the ICU (I=0 outside data ops)
//   result          ICU result register, sampled by SKZ
//   running, halted state flags
//   err             sticky stack overflow/underflow, cleared only by rst
module icu_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [ADDR_W+3:0] prog_data,
    output logic [3:0]        I,
    output logic [ADDR_W-1:0] io_addr,
    input  logic              result,
    output logic              running,
    output logic              halted,
    output logic              err
);

    // sp counts 0..STACK_DEPTH inclusive, so it needs one bit above the index
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc, pc_d, pc_inc, io_d;
    logic [SP_W-1:0]   sp, sp_d, sp_m1;
    logic              skip, skip_d, err_d, push, full;
    logic [3:0]        i_d;
    logic [3:0]        op;
    logic [ADDR_W-1:0] opr;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    assign op        = prog_data[ADDR_W+3:ADDR_W];
    assign opr       = prog_data[ADDR_W-1:0];
    assign pc_inc    = pc + 1'b1;          // wraps modulo 2^ADDR_W
    assign sp_m1     = sp - 1'b1;
    assign full      = (sp == SP_W'(STACK_DEPTH));
    assign prog_addr = pc;
    assign running   = (state == RUN);
    assign halted    = (state == HALT);

    always_comb begin
        state_d = state;
        pc_d    = pc;
        sp_d    = sp;
        skip_d  = skip;
        err_d   = err;
        i_d     = 4'h0;
        io_d    = io_addr;   // operand only refreshed by data opcodes
        push    = 1'b0;
        case (state)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (skip) begin
                    // discarded word: no flow control, no stack effect
                    pc_d   = pc_inc;
                    skip_d = 1'b0;
                end else begin
                    case (op)
                        4'hC: begin
                            pc_d = opr;
                            if (opr == pc) state_d = HALT;   // self-loop terminates the program
                        end
                        4'hD: begin
                            if (sp != '0) begin
                                sp_d = sp_m1;
                                pc_d = stack[sp_m1[SP_W-2:0]];
                            end else begin
                                err_d   = 1'b1;
                                state_d = HALT;
                            end
                        end
                        4'hE: begin
                            skip_d = ~result;
                            pc_d   = pc_inc;
                        end
                        4'hF: begin
                            if (!full) begin
                                push = 1'b1;
                                sp_d = sp + 1'b1;
                                pc_d = opr;
                            end else begin
                                err_d   = 1'b1;
                                state_d = HALT;
                            end
                        end
                        default: begin
                            i_d  = op;
                            io_d = opr;
                            pc_d = pc_inc;
                        end
                    endcase
                end
            end
            HALT: begin
                if (!start) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            sp      <= '0;
            skip    <= 1'b0;
            err     <= 1'b0;
            I       <= 4'h0;
            io_addr <= '0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            sp      <= sp_d;
            skip    <= skip_d;
            err     <= err_d;
            I       <= i_d;
            io_addr <= io_d;
        end
    end

    // Stack contents need no reset; emptiness is tracked by sp alone.
    always_ff @(posedge clk) begin
        if (push) stack[sp[SP_W-2:0]] <= pc_inc;
    end

endmodule

// File: tb/tb_icu_sequencer.sv
module tb_icu_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, result;
    logic [7:0]  prog_addr, io_addr;
    logic [11:0] prog_data;
    logic [3:0]  I;
    logic        running, halted, err;

    logic [11:0] rom [256];
    assign prog_data = rom[prog_addr];

    icu_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .I(I), .io_addr(io_addr), .result(result),
        .running(running), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       r;
        logic [3:0] i;
        logic [7:0] io;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       run;
        logic       hlt;
        logic       er;
    } vec_t;

    vec_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic r, input logic [3:0] i, input logic [7:0] io,
                       input logic [7:0] pc, input logic [2:0] sp,
                       input logic ru, input logic h, input logic e);
        vec_t v;
        v.s = s; v.r = r; v.i = i; v.io = io; v.pc = pc; v.sp = sp;
        v.run = ru; v.hlt = h; v.er = e;
        q.push_back(v);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] op, input logic [7:0] opr);
        rom[a] = {op, opr};
    endtask

    task automatic clear_rom();
        for (int k = 0; k < 256; k++) rom[k] = 12'h000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start  = 1'b0;
        result = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".I"},       32'(I), 32'h0);
        chk({nm, ".io"},      32'(io_addr), 32'h0);
        chk({nm, ".pc"},      32'(prog_addr), 32'h0);
        chk({nm, ".running"}, 32'(running), 32'h0);
        chk({nm, ".halted"},  32'(halted), 32'h0);
        chk({nm, ".err"},     32'(err), 32'h0);
    endtask

    task automatic run_q(input string nm);
        foreach (q[k]) begin
            @(negedge clk);
            start  = q[k].s;
            result = q[k].r;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].I", nm, k),       32'(I), 32'(q[k].i));
            chk($sformatf("%s[%0d].io", nm, k),      32'(io_addr), 32'(q[k].io));
            chk($sformatf("%s[%0d].pc", nm, k),      32'(prog_addr), 32'(q[k].pc));
            chk($sformatf("%s[%0d].sp", nm, k),      32'(dut.sp), 32'(q[k].sp));
            chk($sformatf("%s[%0d].running", nm, k), 32'(running), 32'(q[k].run));
            chk($sformatf("%s[%0d].halted", nm, k),  32'(halted), 32'(q[k].hlt));
            chk($sformatf("%s[%0d].err", nm, k),     32'(err), 32'(q[k].er));
        end
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; result = 1'b0;
        clear_rom();
        #12;
        chk_reset_vals("reset");
        do_reset();
        chk_reset_vals("reset_idle");

        // straight-line code, halts via self-jump at 3, waits for start low
        clear_rom();
        wr(8'h00, 4'h1, 8'h05); wr(8'h01, 4'h2, 8'h06); wr(8'h02, 4'h8, 8'h07); wr(8'h03, 4'hC, 8'h03);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h1,8'h05,8'h01,0, 1,0,0);
        add(1,0, 4'h2,8'h06,8'h02,0, 1,0,0);
        add(1,0, 4'h8,8'h07,8'h03,0, 1,0,0);
        add(1,0, 4'h0,8'h07,8'h03,0, 0,1,0);
        add(1,0, 4'h0,8'h07,8'h03,0, 0,1,0);
        add(0,0, 4'h0,8'h07,8'h00,0, 0,0,0);
        run_q("straight");

        // jump then self-jump halt; start dropped during RUN is ignored
        clear_rom();
        wr(8'h00, 4'hC, 8'h10); wr(8'h10, 4'hC, 8'h10);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(0,0, 4'h0,8'h00,8'h10,0, 1,0,0);
        add(0,0, 4'h0,8'h00,8'h10,0, 0,1,0);
        add(0,0, 4'h0,8'h00,8'h00,0, 0,0,0);
        run_q("jump");

        // SKZ with result low then high
        clear_rom();
        wr(8'h00, 4'hE, 8'h00); wr(8'h01, 4'h1, 8'hAA); wr(8'h02, 4'h2, 8'hBB); wr(8'h03, 4'hC, 8'h03);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h01,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h02,0, 1,0,0);
        add(1,0, 4'h2,8'hBB,8'h03,0, 1,0,0);
        add(1,0, 4'h0,8'hBB,8'h03,0, 0,1,0);
        run_q("skz0");
        do_reset();
        add(1,1, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,1, 4'h0,8'h00,8'h01,0, 1,0,0);
        add(1,1, 4'h1,8'hAA,8'h02,0, 1,0,0);
        add(1,1, 4'h2,8'hBB,8'h03,0, 1,0,0);
        add(1,1, 4'h0,8'hBB,8'h03,0, 0,1,0);
        run_q("skz1");

        // call / return
        clear_rom();
        wr(8'h00, 4'hF, 8'h20); wr(8'h20, 4'hD, 8'h00); wr(8'h01, 4'hC, 8'h01);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h20,1, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h01,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h01,0, 0,1,0);
        run_q("callret");

        // five nested calls overflow a 4-deep stack; err survives HALT->IDLE
        clear_rom();
        wr(8'h00, 4'hF, 8'h10); wr(8'h10, 4'hF, 8'h20); wr(8'h20, 4'hF, 8'h30);
        wr(8'h30, 4'hF, 8'h40); wr(8'h40, 4'hF, 8'h50);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h10,1, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h20,2, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h30,3, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h40,4, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h40,4, 0,1,1);
        add(0,0, 4'h0,8'h00,8'h00,4, 0,0,1);
        run_q("overflow");

        // async reset between edges clears sticky err immediately
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("rst_err");
        @(negedge clk);
        rst = 1'b0;

        // skipped CALL with a full stack raises no err
        wr(8'h40, 4'hE, 8'h00); wr(8'h41, 4'hF, 8'h50); wr(8'h42, 4'hC, 8'h42);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h10,1, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h20,2, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h30,3, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h40,4, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h41,4, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h42,4, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h42,4, 0,1,0);
        run_q("skipfull");

        // RTN with empty stack
        clear_rom();
        wr(8'h00, 4'hD, 8'h00);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h00,0, 0,1,1);
        run_q("underflow");

        // CALL at the last address pushes 0
        clear_rom();
        wr(8'h00, 4'hC, 8'hFF); wr(8'hFF, 4'hF, 8'h20); wr(8'h20, 4'hD, 8'h00);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'hFF,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h20,1, 1,0,0);
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h0,8'h00,8'hFF,0, 1,0,0);
        run_q("wrap");

        // async reset mid-RUN, asserted while clk is high
        clear_rom();
        wr(8'h00, 4'h1, 8'h05); wr(8'h01, 4'h2, 8'h06); wr(8'h02, 4'h8, 8'h07);
        do_reset();
        add(1,0, 4'h0,8'h00,8'h00,0, 1,0,0);
        add(1,0, 4'h1,8'h05,8'h01,0, 1,0,0);
        add(1,0, 4'h2,8'h06,8'h02,0, 1,0,0);
        run_q("prerst");
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        chk("rst_mid.sp", 32'(dut.sp), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
